// File: rtl/ones_counter_pipe_pkg.sv
// Shared TDC constants and elaboration-time helpers for the population-count pipeline.
// Leaf width and sizing functions are used by every ones-counter file.
package ones_counter_pipe_pkg;

    localparam int unsigned TDC_LEAF_W = 6;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of operands present at a given adder-tree level (odd ones pass through).
    function automatic int unsigned level_count(input int unsigned nleaf, input int unsigned lvl);
        int unsigned n;
        n = nleaf;
        for (int unsigned k = 0; k < lvl; k++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/ones_counter_pipe_6to3.sv
// Combinational popcount of one 6-bit delay-line slice into a 3-bit count.
module ones_counter_6to3
    import ones_counter_pipe_pkg::*;
(
    input  logic [TDC_LEAF_W-1:0] i_Bits,
    output logic [2:0]            o_Count
);

    always_comb begin
        o_Count = '0;
        for (int unsigned i = 0; i < TDC_LEAF_W; i++) begin
            o_Count = o_Count + 3'(i_Bits[i]);
        end
    end

endmodule

// File: rtl/ones_counter_pipe.sv
// Pipelined population counter for TDC thermometer words, with valid tagging and a
// peak-hold of the largest count since reset or clear.
module ones_counter_pipe
    import ones_counter_pipe_pkg::*;
#(
    parameter  int unsigned WIDTH = 72,
    localparam int unsigned CW    = clog2(WIDTH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Reset_N,
    input  logic             i_Valid,
    input  logic [WIDTH-1:0] i_Sequence,
    input  logic             i_Clear,
    output logic             o_Valid,
    output logic [CW-1:0]    o_Count,
    output logic [CW-1:0]    o_Peak
);

    localparam int unsigned NLEAF = (WIDTH + TDC_LEAF_W - 1) / TDC_LEAF_W;
    localparam int unsigned LAT   = 1 + clog2(NLEAF);
    localparam int unsigned PW    = NLEAF * TDC_LEAF_W;

    logic [PW-1:0]  padded;
    logic [LAT-1:0] vld;
    logic [LAT-1:0] ld;
    logic [CW-1:0]  result;
    logic           result_vld;

    assign padded = PW'(i_Sequence);

    // ld[k] is the load enable of tree level k, i.e. the valid of the sample entering it.
    assign ld[0] = i_Valid;
    if (LAT > 1) begin : g_ld
        assign ld[LAT-1:1] = vld[LAT-2:0];
    end

    always_ff @(posedge i_Clk or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            vld <= '0;
        end else begin
            vld <= ld;
        end
    end

    for (genvar lvl = 0; lvl < LAT; lvl++) begin : g_lvl
        localparam int unsigned N  = level_count(NLEAF, lvl);
        localparam int unsigned LW = 3 + lvl;

        logic [LW-1:0] nxt [N];
        logic [LW-1:0] sum [N];

        if (lvl == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_cnt
                ones_counter_6to3 u_cnt (
                    .i_Bits  (padded[i*TDC_LEAF_W +: TDC_LEAF_W]),
                    .o_Count (nxt[i])
                );
            end
        end else begin : g_add
            localparam int unsigned NP = level_count(NLEAF, lvl - 1);
            for (genvar i = 0; i < N; i++) begin : g_pair
                if (2 * i + 1 < NP) begin : g_sum
                    assign nxt[i] = LW'(g_lvl[lvl-1].sum[2*i]) + LW'(g_lvl[lvl-1].sum[2*i+1]);
                end else begin : g_pass
                    assign nxt[i] = LW'(g_lvl[lvl-1].sum[2*i]);
                end
            end
        end

        always_ff @(posedge i_Clk or negedge i_Reset_N) begin
            if (!i_Reset_N) begin
                for (int unsigned i = 0; i < N; i++) begin
                    sum[i] <= '0;
                end
            end else if (ld[lvl]) begin
                for (int unsigned i = 0; i < N; i++) begin
                    sum[i] <= nxt[i];
                end
            end
        end
    end

    // The tree root never exceeds WIDTH, so narrowing to CW bits loses nothing.
    assign result     = CW'(g_lvl[LAT-1].nxt[0]);
    assign result_vld = ld[LAT-1];
    assign o_Count    = CW'(g_lvl[LAT-1].sum[0]);
    assign o_Valid    = vld[LAT-1];

    always_ff @(posedge i_Clk or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            o_Peak <= '0;
        end else if (i_Clear && result_vld) begin
            o_Peak <= result;
        end else if (i_Clear) begin
            o_Peak <= '0;
        end else if (result_vld && (result > o_Peak)) begin
            o_Peak <= result;
        end
    end

endmodule

// File: tb/tb_ones_counter_pipe.sv
// Directed checks of ones_counter_pipe at WIDTH=72 (LAT=5) and WIDTH=20 (LAT=3).
module tb_ones_counter_pipe;

    logic        clk;
    logic        rst_n;

    logic        valid;
    logic [71:0] seq;
    logic        clr;
    logic        ov;
    logic [6:0]  oc;
    logic [6:0]  op;

    logic        valid20;
    logic [19:0] seq20;
    logic        clr20;
    logic        ov20;
    logic [4:0]  oc20;
    logic [4:0]  op20;

    int checks;
    int errors;

    ones_counter_pipe #(.WIDTH(72)) dut (
        .i_Clk      (clk),
        .i_Reset_N  (rst_n),
        .i_Valid    (valid),
        .i_Sequence (seq),
        .i_Clear    (clr),
        .o_Valid    (ov),
        .o_Count    (oc),
        .o_Peak     (op)
    );

    ones_counter_pipe #(.WIDTH(20)) dut20 (
        .i_Clk      (clk),
        .i_Reset_N  (rst_n),
        .i_Valid    (valid20),
        .i_Sequence (seq20),
        .i_Clear    (clr20),
        .o_Valid    (ov20),
        .o_Count    (oc20),
        .o_Peak     (op20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (ov !== 1'b0 || oc !== 7'd0 || op !== 7'd0) begin
            errors++;
            $display("FAIL reset72 valid=%b count=%0d peak=%0d required 0 0 0", ov, oc, op);
        end
        checks++;
        if (ov20 !== 1'b0 || oc20 !== 5'd0 || op20 !== 5'd0) begin
            errors++;
            $display("FAIL reset20 valid=%b count=%0d peak=%0d required 0 0 0", ov20, oc20, op20);
        end
    endtask

    task automatic test_latency();
        seq   = 72'h0000_0000_0000_00FFFF;
        valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                valid = 1'b0;
                seq   = '0;
            end
            checks++;
            if (ov !== (k == 5)) begin
                errors++;
                $display("FAIL latency_valid edge=%0d got=%b required=%b", k, ov, (k == 5));
            end
            if (k == 5) begin
                checks++;
                if (oc !== 7'd16 || op !== 7'd16) begin
                    errors++;
                    $display("FAIL latency_count count=%0d peak=%0d required 16 16", oc, op);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] w [3];
        int          exp_c [10];
        bit          exp_v [10];
        w[0] = '0;
        w[1] = '1;
        w[2] = '1;
        w[2] = w[2] >> 35;
        exp_c = '{16, 16, 16, 16, 0, 72, 37, 37, 37, 37};
        exp_v = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        for (int e = 1; e <= 10; e++) begin
            if (e <= 3) begin
                valid = 1'b1;
                seq   = w[e-1];
            end else begin
                valid = 1'b0;
                seq   = '0;
            end
            tick();
            checks++;
            if (ov !== exp_v[e-1] || oc !== 7'(exp_c[e-1])) begin
                errors++;
                $display("FAIL b2b edge=%0d valid=%b count=%0d required %b %0d",
                         e, ov, oc, exp_v[e-1], exp_c[e-1]);
            end
        end
        checks++;
        if (op !== 7'd72) begin
            errors++;
            $display("FAIL b2b_peak got=%0d required=72", op);
        end
    endtask

    task automatic test_bubbles();
        logic [71:0] w38;
        w38     = '1;
        w38     = w38 >> 32;
        w38[10] = 1'b0;
        w38[25] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            valid = (e <= 2);
            seq   = (e == 1) ? w38 : ((e == 2) ? '1 : '0);
            tick();
            if (e == 5) begin
                checks++;
                if (ov !== 1'b1 || oc !== 7'd38) begin
                    errors++;
                    $display("FAIL bubbles valid=%b count=%0d required 1 38", ov, oc);
                end
            end
            if (e == 6) begin
                checks++;
                if (ov !== 1'b1 || oc !== 7'd72) begin
                    errors++;
                    $display("FAIL all_ones valid=%b count=%0d required 1 72", ov, oc);
                end
            end
        end
        valid = 1'b0;
        seq   = '0;
    endtask

    task automatic test_peak_clear();
        valid = 1'b1;
        seq   = 72'h1F;
        tick();
        valid = 1'b0;
        seq   = '0;
        tick();
        tick();
        tick();
        checks++;
        if (ov !== 1'b0 || op !== 7'd72) begin
            errors++;
            $display("FAIL peak_before_clear valid=%b peak=%0d required 0 72", ov, op);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (ov !== 1'b1 || oc !== 7'd5 || op !== 7'd5) begin
            errors++;
            $display("FAIL clear_with_result valid=%b count=%0d peak=%0d required 1 5 5", ov, oc, op);
        end
        tick();
        checks++;
        if (op !== 7'd5) begin
            errors++;
            $display("FAIL peak_hold got=%0d required=5", op);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (ov !== 1'b0 || op !== 7'd0) begin
            errors++;
            $display("FAIL clear_no_result valid=%b peak=%0d required 0 0", ov, op);
        end
    endtask

    task automatic test_async_reset();
        seq = '1;
        for (int e = 1; e <= 7; e++) begin
            valid = (e <= 6);
            tick();
        end
        valid = 1'b0;
        seq   = '0;
        checks++;
        if (ov !== 1'b1 || oc !== 7'd72 || op !== 7'd72) begin
            errors++;
            $display("FAIL pre_reset valid=%b count=%0d peak=%0d required 1 72 72", ov, oc, op);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov !== 1'b0 || oc !== 7'd0 || op !== 7'd0) begin
            errors++;
            $display("FAIL async_reset valid=%b count=%0d peak=%0d required 0 0 0", ov, oc, op);
        end
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (ov !== 1'b0 || oc !== 7'd0 || op !== 7'd0) begin
                errors++;
                $display("FAIL stale_after_reset edge=%0d valid=%b count=%0d peak=%0d required 0 0 0",
                         e, ov, oc, op);
            end
        end
    endtask

    task automatic test_odd_width();
        bit          hv [$];
        int unsigned hc [$];
        bit          ev;
        int unsigned ec;
        int unsigned exp_cnt;
        int unsigned exp_pk;
        logic [19:0] w;
        exp_cnt = 0;
        exp_pk  = 0;
        hv.push_back(1'b0); hc.push_back(0);
        hv.push_back(1'b0); hc.push_back(0);
        for (int t = 0; t < 60; t++) begin
            valid20 = ($urandom_range(0, 1) == 1);
            if (valid20) begin
                w     = 20'($urandom);
                if (t == 10) w = '1;
                seq20 = w;
                hv.push_back(1'b1);
                hc.push_back($countones(w));
            end else begin
                seq20 = 'x;
                hv.push_back(1'b0);
                hc.push_back(0);
            end
            tick();
            ev = hv.pop_front();
            ec = hc.pop_front();
            if (ev) begin
                exp_cnt = ec;
                if (ec > exp_pk) exp_pk = ec;
            end
            checks++;
            if (ov20 !== ev || oc20 !== 5'(exp_cnt) || op20 !== 5'(exp_pk)) begin
                errors++;
                $display("FAIL odd_width cycle=%0d valid=%b count=%0d peak=%0d required %b %0d %0d",
                         t, ov20, oc20, op20, ev, exp_cnt, exp_pk);
            end
        end
        valid20 = 1'b0;
        seq20   = '0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        valid   = 1'b0;
        seq     = '0;
        clr     = 1'b0;
        valid20 = 1'b0;
        seq20   = '0;
        clr20   = 1'b0;
        tick();
        tick();
        test_reset();
        #3;
        rst_n = 1'b1;
        tick();
        test_latency();
        test_back_to_back();
        test_bubbles();
        test_peak_clear();
        test_async_reset();
        test_odd_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
